sparc_ram_responder: RTL

- Memory-side responder for the MPU's MOV/MOC memory handshake. It is the counterpart of the control-unit initiator that drives MOV, r_w, type and the MAR address.
- Holds 512 bytes of big-endian, byte-addressed storage.
- Serves byte, halfword and word reads and writes with a programmable access latency.
- Flags misaligned or illegal accesses instead of corrupting memory.

---
 rtl/sparc_mem_pkg.sv | 27 ++
 rtl/sparc_mem_array.sv | 33 +++
 rtl/sparc_ram_responder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sparc_mem_pkg.sv
// sparc_mem_pkg: shared definitions for the MOV/MOC memory responder.
//   - access-size encodings carried on the responder's acc_type port
//   - responder FSM state type
//   - aligned(): legality of an access size at a given low address
package sparc_mem_pkg;

  localparam logic [1:0] TYPE_BYTE = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;
  localparam logic [1:0] TYPE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // 1 when an access of size t may start at an address ending in addr_lo.
  function automatic logic aligned(input logic [1:0] t, input logic [1:0] addr_lo);
    case (t)
      TYPE_BYTE: aligned = 1'b1;
      TYPE_HALF: aligned = (addr_lo[0] == 1'b0);
      TYPE_WORD: aligned = (addr_lo == 2'b00);
      default:   aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sparc_mem_array.sv
// sparc_mem_array: 2**ADDR_W x 8 byte storage, no reset.
//   clk    in   write clock
//   we     in   4-lane byte write enable; lane 3 (bits [31:24]) is byte addr
//   addr   in   base byte address for both ports
//   wdata  in   big-endian write data: [31:24]->addr, [23:16]->addr+1, ...
//   rdata  out  big-endian combinational read of addr..addr+3
// Lane addresses wrap modulo the depth; callers only use in-range lanes.
module sparc_mem_array #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[3-i]) mem[addr + ADDR_W'(i)] <= wdata[31-8*i -: 8];
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      rdata[31-8*i -: 8] = mem[addr + ADDR_W'(i)];
    end
  end

endmodule

// File: rtl/sparc_ram_responder.sv
// sparc_ram_responder: memory-side responder of the MOV/MOC handshake.
//   Clk       in   system clock
//   Clr       in   synchronous active-high reset (storage is kept)
//   MOV       in   request, held high until MOC is seen
//   r_w       in   1 = read, 0 = write
//   acc_type  in   00 byte, 01 halfword, 10 word, 11 illegal
//   Address   in   byte address
//   DataIn    in   right-justified write data
//   DataOut   out  right-justified, zero-extended read data
//   MOC       out  operation complete
//   ERR       out  access rejected (valid with MOC)
// LATENCY (1..15) is the number of edges from acceptance to MOC.
module sparc_ram_responder
  import sparc_mem_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              MOV,
  input  logic              r_w,
  // "type" is a reserved word in SystemVerilog, hence acc_type.
  input  logic [1:0]        acc_type,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              ERR
);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_type;
  logic              req_rw;
  logic [31:0]       req_data;

  logic              fire;
  logic              legal;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic [31:0]       rd;
  logic [31:0]       rd_val;

  assign fire  = (state == BUSY) && (cnt == 4'd0);
  assign legal = aligned(req_type, req_addr[1:0]);

  // Steer right-justified data to/from the big-endian lanes at req_addr.
  always_comb begin
    be     = '0;
    wd     = '0;
    rd_val = '0;
    case (req_type)
      TYPE_BYTE: begin
        be     = 4'b1000;
        wd     = {req_data[7:0], 24'h0};
        rd_val = {24'h0, rd[31:24]};
      end
      TYPE_HALF: begin
        be     = 4'b1100;
        wd     = {req_data[15:0], 16'h0};
        rd_val = {16'h0, rd[31:16]};
      end
      TYPE_WORD: begin
        be     = 4'b1111;
        wd     = req_data;
        rd_val = rd;
      end
      default: ;
    endcase
    if (!(fire && legal && !req_rw && !Clr)) be = '0;
  end

  sparc_mem_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (Clk),
    .we    (be),
    .addr  (req_addr),
    .wdata (wd),
    .rdata (rd)
  );

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state   <= IDLE;
      MOC     <= 1'b0;
      ERR     <= 1'b0;
      DataOut <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MOV) begin
            req_addr <= Address;
            req_type <= acc_type;
            req_rw   <= r_w;
            req_data <= DataIn;
            cnt      <= 4'(LATENCY - 1);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            MOC   <= 1'b1;
            state <= DONE;
            if (!legal) begin
              ERR     <= 1'b1;
              DataOut <= '0;
            end else if (req_rw) begin
              DataOut <= rd_val;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (!MOV) begin
            MOC   <= 1'b0;
            ERR   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
